// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sequencer that shares one UART transmitter among N_REQ byte sources.
// The winning byte and parity config are held locally until the transmitter drops BUSY.

module uart_tx_arb_lane #(
  parameter  int N_REQ = 4,
  parameter  int IDX   = 0,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic [GW-1:0] ptr,
  input  logic          valid,
  output logic          upper
);
  // requester is pending and sits at or after the round-robin pointer
  assign upper = valid && (GW'(IDX) >= ptr);
endmodule

module uart_tx_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int DATA_W   = 8,
  parameter  int WAIT_MAX = 15,
  localparam int GW       = $clog2(N_REQ),
  localparam int CW       = $clog2(WAIT_MAX + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        REQ_VALID,
  input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]        REQ_PAR_EN,
  input  logic [N_REQ-1:0]        REQ_PAR_TYP,
  output logic [N_REQ-1:0]        REQ_READY,
  output logic [DATA_W-1:0]       TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic                    TX_PAR_EN,
  output logic                    TX_PAR_TYP,
  input  logic                    TX_BUSY,
  output logic [GW-1:0]           GNT_ID,
  output logic                    ACTIVE,
  output logic                    TIMEOUT_ERR
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              par_en;
    logic              par_typ;
  } req_t;

  state_t           state;
  logic [GW-1:0]    ptr, pick;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [N_REQ-1:0] upper;
  logic             grant;
  req_t             sel;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    uart_tx_arb_lane #(.N_REQ(N_REQ), .IDX(i)) u_lane (
      .ptr   (ptr),
      .valid (REQ_VALID[i]),
      .upper (upper[i])
    );
  end

  // Lowest pending index at/after the pointer wins; otherwise wrap to the lowest pending index.
  always_comb begin
    pick = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (REQ_VALID[i]) pick = GW'(i);
    if (|upper)
      for (int i = N_REQ-1; i >= 0; i--)
        if (upper[i]) pick = GW'(i);
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick == GW'(i)) begin
        sel.data    = REQ_DATA[i*DATA_W +: DATA_W];
        sel.par_en  = REQ_PAR_EN[i];
        sel.par_typ = REQ_PAR_TYP[i];
      end
  end

  // A busy transmitter in IDLE means a foreign frame is still on the line.
  assign grant   = !RST && (state == IDLE) && !TX_BUSY && (|REQ_VALID);
  assign cnt_nxt = cnt + CW'(1);

  always_comb begin
    REQ_READY = '0;
    for (int i = 0; i < N_REQ; i++)
      REQ_READY[i] = grant && (pick == GW'(i));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      TX_PAR_EN     <= 1'b0;
      TX_PAR_TYP    <= 1'b0;
      GNT_ID        <= '0;
      ACTIVE        <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      TX_DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            TX_P_DATA     <= sel.data;
            TX_PAR_EN     <= sel.par_en;
            TX_PAR_TYP    <= sel.par_typ;
            GNT_ID        <= pick;
            ptr           <= (pick == GW'(N_REQ-1)) ? '0 : pick + GW'(1);
            TX_DATA_VALID <= 1'b1;
            ACTIVE        <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == CW'(WAIT_MAX)) begin
              TIMEOUT_ERR <= 1'b1;
              ACTIVE      <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            ACTIVE <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
